// File: rtl/vmem_arbiter.sv
// Video memory arbiter: shares a single-port synchronous-read RAM between the
// CPU load/store path and the real-time scanout engine, with a CPU starvation guard.
module vmem_arbiter #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_ack_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  wait_inc;
  logic              vid_win;

  assign wait_inc = (wait_cnt_q == CNT_SAT) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

  // Next-state, latch and output decode
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    vid_win     = 1'b0;
    cpu_ack_o   = 1'b0;
    cpu_rdata_o = '0;
    vid_ack_o   = 1'b0;
    vid_rdata_o = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Scanout wins unless the CPU has already lost MAX_WAIT rounds in a row
        vid_win = vid_req_i && (!cpu_req_i || (wait_cnt_q < WAIT_LIM));
        if (vid_win) begin
          owner_d     = OWN_VID;
          lat_we_d    = 1'b0;
          lat_addr_d  = vid_addr_i;
          lat_wdata_d = '0;
          wait_cnt_d  = cpu_req_i ? wait_inc : '0;
          state_d     = ST_ACC;
        end else if (cpu_req_i) begin
          owner_d     = OWN_CPU;
          lat_we_d    = cpu_we_i;
          lat_addr_d  = cpu_addr_i;
          lat_wdata_d = cpu_wdata_i;
          wait_cnt_d  = '0;
          state_d     = ST_ACC;
        end else begin
          wait_cnt_d  = '0;
        end
      end

      ST_ACC: begin
        // Strobes are gated by rst so an aborted access never reaches the RAM
        mem_en_o    = !rst;
        mem_we_o    = lat_we_q && !rst;
        mem_addr_o  = lat_addr_q;
        mem_wdata_o = lat_wdata_q;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (owner_q == OWN_CPU) begin
          cpu_ack_o   = 1'b1;
          cpu_rdata_o = lat_we_q ? '0 : mem_rdata_i;
        end else begin
          vid_ack_o   = 1'b1;
          vid_rdata_o = mem_rdata_i;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_VID;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level arbitration model and a behavioural RAM.
module tb_vmem_arbiter;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  vmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_ack_o(vid_ack), .vid_rdata_o(vid_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return 32'hA5C3_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  // Behavioural single-port synchronous-read RAM, preset on the first edge
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  bit ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1<<ADDR_W); i++) ram[i] <= init_val(ADDR_W'(i));
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] sh_read(input logic [ADDR_W-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [114:0] obs;
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0;
    repeat (3) step();
    obs = {cpu_ack, vid_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, vid_rdata};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_held: got %h required 0", obs); end
    rst = 1'b0;
    step();
    obs = {cpu_ack, vid_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, vid_rdata};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_idle: got %h required 0", obs); end
  endtask

  task automatic test_cpu_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0010; cpu_wdata = 32'hDEADBEEF;
    step();
    checks++;
    if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL wr_acc_strobe: got %b required 11", {mem_en, mem_we}); end
    checks++;
    if (mem_addr !== 15'h0010) begin errors++; $display("FAIL wr_acc_addr: got %h required 0010", mem_addr); end
    checks++;
    if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_acc_wdata: got %h required deadbeef", mem_wdata); end
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack: got %b required 0", cpu_ack); end
    step();
    checks++;
    if ({cpu_ack, vid_ack, mem_en} !== 3'b100) begin errors++; $display("FAIL wr_resp: got %b required 100", {cpu_ack, vid_ack, mem_en}); end
    checks++;
    if (cpu_rdata !== '0) begin errors++; $display("FAIL wr_rdata_zero: got %h required 0", cpu_rdata); end
    cpu_req = 0; cpu_we = 0;
    step();
    checks++;
    if ({cpu_ack, mem_en} !== 2'b00) begin errors++; $display("FAIL wr_after: got %b required 00", {cpu_ack, mem_en}); end
  endtask

  task automatic test_readback();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0010;
    step();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 15'h0010}) begin
      errors++; $display("FAIL rd_acc: got en=%b we=%b addr=%h required en=1 we=0 addr=0010", mem_en, mem_we, mem_addr);
    end
    step();
    checks++;
    if ({cpu_ack, vid_ack} !== 2'b10) begin errors++; $display("FAIL rd_acks: got %b required 10", {cpu_ack, vid_ack}); end
    checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h required deadbeef", cpu_rdata); end
    checks++;
    if (vid_rdata !== '0) begin errors++; $display("FAIL rd_vid_rdata: got %h required 0", vid_rdata); end
    cpu_req = 0;
    step();
  endtask

  task automatic test_simultaneous();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0010;
    vid_req = 1; vid_addr = 15'h0100;
    step();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 15'h0100}) begin
      errors++; $display("FAIL sim_vid_first: got en=%b we=%b addr=%h required en=1 we=0 addr=0100", mem_en, mem_we, mem_addr);
    end
    step();
    checks++;
    if ({vid_ack, cpu_ack} !== 2'b10) begin errors++; $display("FAIL sim_vid_ack: got %b required 10", {vid_ack, cpu_ack}); end
    checks++;
    if (vid_rdata !== init_val(15'h0100)) begin errors++; $display("FAIL sim_vid_data: got %h required %h", vid_rdata, init_val(15'h0100)); end
    vid_req = 0;
    step();
    checks++;
    if ({mem_en, cpu_ack, vid_ack} !== 3'b000) begin errors++; $display("FAIL sim_gap: got %b required 000", {mem_en, cpu_ack, vid_ack}); end
    step();
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 15'h0010}) begin errors++; $display("FAIL sim_cpu_acc: got en=%b addr=%h required en=1 addr=0010", mem_en, mem_addr); end
    step();
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL sim_cpu_ack: got ack=%b data=%h required ack=1 data=deadbeef", cpu_ack, cpu_rdata); end
    cpu_req = 0;
    step();
  endtask

  task automatic test_starvation();
    string seq = "";
    int    acks = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0010;
    vid_req = 1; vid_addr = 15'h0100;
    for (int c = 0; c < 40 && acks < 6; c++) begin
      step();
      if (vid_ack === 1'b1) begin
        checks++;
        if (vid_rdata !== init_val(vid_addr)) begin errors++; $display("FAIL starve_vid_data: got %h required %h", vid_rdata, init_val(vid_addr)); end
        seq = {seq, "V"};
        vid_addr = vid_addr + 15'd1;
        acks++;
      end
      if (cpu_ack === 1'b1) begin
        checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL starve_cpu_data: got %h required deadbeef", cpu_rdata); end
        seq = {seq, "C"};
        cpu_req = 0;
        acks++;
      end
    end
    checks++;
    if (seq != "VVVVCV") begin errors++; $display("FAIL starve_order: got '%s' required 'VVVVCV'", seq); end
    vid_req = 0; cpu_req = 0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    logic [114:0] obs;
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0020; cpu_wdata = 32'h1234_5678;
    step();
    checks++;
    if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_acc: got en=%b required 1", mem_en); end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL rstmid_gate: got %b required 00", {mem_en, mem_we}); end
    step();
    rst = 1'b0; cpu_req = 0; cpu_we = 0;
    #1;
    obs = {cpu_ack, vid_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, vid_rdata};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL rstmid_idle: got %h required 0", obs); end
    step();
    obs = {cpu_ack, vid_ack, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, vid_rdata};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL rstmid_next: got %h required 0", obs); end
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0020;
    step(); step();
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, init_val(15'h0020)}) begin
      errors++; $display("FAIL rstmid_mem: got ack=%b data=%h required ack=1 data=%h", cpu_ack, cpu_rdata, init_val(15'h0020));
    end
    cpu_req = 0;
    step();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({mem_en, cpu_ack, vid_ack} !== 3'b000) begin errors++; $display("FAIL idle_quiet cyc%0d: got %b required 000", c, {mem_en, cpu_ack, vid_ack}); end
    end
  endtask

  // Transaction-level model: an access occupies the memory for a grant cycle,
  // an access cycle and a response cycle; the CPU may lose at most MAX_WAIT times.
  task automatic test_random();
    int                busy = 0;
    int                lost = 0;
    bit                own_cpu = 0, exp_we = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_wdata = '0, exp_data = '0;
    bit                cpu_pend = 0, vid_pend = 0;
    bit                e_cack, e_vack;
    shadow.delete();
    rst = 1; cpu_req = 0; vid_req = 0;
    step();
    rst = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (busy == 0) begin
        if (vid_req && (!cpu_req || lost < int'(MAX_WAIT))) begin
          lost = cpu_req ? ((lost < 15) ? lost + 1 : 15) : 0;
          own_cpu = 0; exp_we = 0; exp_addr = vid_addr; exp_wdata = '0;
          exp_data = sh_read(vid_addr); busy = 2;
        end else if (cpu_req) begin
          lost = 0;
          own_cpu = 1; exp_we = cpu_we; exp_addr = cpu_addr; exp_wdata = cpu_wdata;
          exp_data = cpu_we ? '0 : sh_read(cpu_addr);
          if (cpu_we) shadow[cpu_addr] = cpu_wdata;
          busy = 2;
        end else begin
          lost = 0;
        end
      end else begin
        busy--;
      end
      e_cack = (busy == 1) && own_cpu;
      e_vack = (busy == 1) && !own_cpu;
      checks++;
      if ({cpu_ack, vid_ack} !== {e_cack, e_vack}) begin
        errors++; $display("FAIL rnd_acks cyc%0d: got %b required %b", cyc, {cpu_ack, vid_ack}, {e_cack, e_vack});
      end
      checks++;
      if (cpu_rdata !== (e_cack ? exp_data : '0) || vid_rdata !== (e_vack ? exp_data : '0)) begin
        errors++; $display("FAIL rnd_rdata cyc%0d: got cpu=%h vid=%h required %h to %s", cyc, cpu_rdata, vid_rdata, exp_data, own_cpu ? "cpu" : "vid");
      end
      checks++;
      if (busy == 2) begin
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, exp_we, exp_addr, exp_wdata}) begin
          errors++; $display("FAIL rnd_acc cyc%0d: got en=%b we=%b addr=%h wd=%h required en=1 we=%b addr=%h wd=%h",
                             cyc, mem_en, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wdata);
        end
      end else if ({mem_en, mem_we} !== 2'b00) begin
        errors++; $display("FAIL rnd_quiet cyc%0d: got %b required 00", cyc, {mem_en, mem_we});
      end
      if (e_cack) cpu_pend = 0;
      if (e_vack) vid_pend = 0;
      if (!cpu_pend && $urandom_range(0, 2) != 0) begin
        cpu_pend  = 1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 15'h0200 + ADDR_W'($urandom_range(0, 63));
        cpu_wdata = $urandom;
      end
      if (!vid_pend && $urandom_range(0, 3) != 0) begin
        vid_pend = 1;
        vid_addr = 15'h0200 + ADDR_W'($urandom_range(0, 63));
      end
      cpu_req = cpu_pend;
      vid_req = vid_pend;
    end
    cpu_req = 0; vid_req = 0;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_readback();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
